// File: rtl/axi_bus_arbiter_if.sv
// Signal bundle between the icache/dcache engines, the shared AXI3 master port
// and the arbiter. The arbiter connects through the master modport.
interface axi_bus_arbiter_if;
  logic [31:0] i_araddr;
  logic [3:0]  i_arlen;
  logic        i_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic        i_rlast;
  logic        i_rvalid;

  logic [31:0] d_araddr;
  logic [3:0]  d_arlen;
  logic        d_arvalid;
  logic        d_arready;
  logic [31:0] d_rdata;
  logic        d_rlast;
  logic        d_rvalid;
  logic [31:0] d_awaddr;
  logic [3:0]  d_awlen;
  logic        d_awvalid;
  logic        d_awready;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wlast;
  logic        d_wvalid;
  logic        d_wready;
  logic        d_bvalid;

  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;
  logic        m_bvalid;
  logic        m_bready;

  logic        dcache_active;

  modport master (
    input  i_araddr, i_arlen, i_arvalid,
    output i_arready, i_rdata, i_rlast, i_rvalid,
    input  d_araddr, d_arlen, d_arvalid,
    output d_arready, d_rdata, d_rlast, d_rvalid,
    input  d_awaddr, d_awlen, d_awvalid,
    output d_awready,
    input  d_wdata, d_wstrb, d_wlast, d_wvalid,
    output d_wready, d_bvalid,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rid, m_rdata, m_rlast, m_rvalid,
    output m_rready,
    output m_awid, m_awaddr, m_awlen, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready, m_bvalid,
    output m_bready, dcache_active
  );

  modport slave (
    output i_araddr, i_arlen, i_arvalid,
    input  i_arready, i_rdata, i_rlast, i_rvalid,
    output d_araddr, d_arlen, d_arvalid,
    input  d_arready, d_rdata, d_rlast, d_rvalid,
    output d_awaddr, d_awlen, d_awvalid,
    input  d_awready,
    output d_wdata, d_wstrb, d_wlast, d_wvalid,
    input  d_wready, d_bvalid,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rid, m_rdata, m_rlast, m_rvalid,
    input  m_rready,
    input  m_awid, m_awaddr, m_awlen, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready, m_bvalid,
    input  m_bready, dcache_active
  );
endinterface

// File: rtl/axi_bus_arbiter.sv
// Shares one AXI3 master port between the icache (read) and dcache (read/write)
// engines: one read burst and one write burst outstanding, dcache read priority.
module axi_bus_arbiter #(
  parameter int unsigned LINE_BITS = 5,
  parameter logic [3:0]  ID_I      = 4'd0,
  parameter logic [3:0]  ID_D      = 4'd1
) (
  input logic               aclk,
  input logic               aresetn,
  axi_bus_arbiter_if.master bus
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic [1:0]  rstate_q, rstate_d;
  logic        grant_q, grant_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  arlen_q, arlen_d;

  logic [1:0]  wstate_q, wstate_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [3:0]  awlen_q, awlen_d;
  logic        wdone_q, wdone_d;

  logic w_busy, i_raw, d_raw, take_i, take_d, r_hit, w_pass, w_last_hs;

  assign w_busy = (wstate_q != W_IDLE);
  assign i_raw  = w_busy && (bus.i_araddr[31:LINE_BITS] == awaddr_q[31:LINE_BITS]);
  assign d_raw  = w_busy && (bus.d_araddr[31:LINE_BITS] == awaddr_q[31:LINE_BITS]);
  assign take_d = (rstate_q == R_IDLE) && bus.d_arvalid && !d_raw;
  assign take_i = (rstate_q == R_IDLE) && bus.i_arvalid && !i_raw && !take_d;
  assign r_hit  = (rstate_q == R_DATA) && bus.m_rvalid &&
                  (bus.m_rid == ((grant_q == GNT_D) ? ID_D : ID_I));

  // W beats may run ahead of AW; once the last one is through in W_ADDR,
  // further beats are held off until AW completes.
  assign w_pass    = ((wstate_q == W_ADDR) && !wdone_q) || (wstate_q == W_DATA);
  assign w_last_hs = w_pass && bus.d_wvalid && bus.m_wready && bus.d_wlast;

  always_comb begin
    rstate_d = rstate_q;
    grant_d  = grant_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    case (rstate_q)
      R_IDLE: begin
        if (take_d) begin
          grant_d  = GNT_D;
          araddr_d = bus.d_araddr;
          arlen_d  = bus.d_arlen;
          rstate_d = R_ADDR;
        end else if (take_i) begin
          grant_d  = GNT_I;
          araddr_d = bus.i_araddr;
          arlen_d  = bus.i_arlen;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR:  if (bus.m_arready) rstate_d = R_DATA;
      R_DATA:  if (r_hit && bus.m_rlast) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    wdone_d  = wdone_q;
    case (wstate_q)
      W_IDLE: begin
        if (bus.d_awvalid) begin
          awaddr_d = bus.d_awaddr;
          awlen_d  = bus.d_awlen;
          wdone_d  = 1'b0;
          wstate_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (bus.m_awready) begin
          wstate_d = (wdone_q || w_last_hs) ? W_RESP : W_DATA;
          wdone_d  = 1'b0;
        end else if (w_last_hs) begin
          wdone_d = 1'b1;
        end
      end
      W_DATA:  if (w_last_hs) wstate_d = W_RESP;
      W_RESP:  if (bus.m_bvalid) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q <= R_IDLE;
      grant_q  <= GNT_I;
      araddr_q <= '0;
      arlen_q  <= '0;
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      awlen_q  <= '0;
      wdone_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      grant_q  <= grant_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      wdone_q  <= wdone_d;
    end
  end

  assign bus.i_arready = take_i;
  assign bus.d_arready = take_d;
  assign bus.i_rdata   = bus.m_rdata;
  assign bus.i_rlast   = bus.m_rlast;
  assign bus.i_rvalid  = r_hit && (grant_q == GNT_I);
  assign bus.d_rdata   = bus.m_rdata;
  assign bus.d_rlast   = bus.m_rlast;
  assign bus.d_rvalid  = r_hit && (grant_q == GNT_D);

  assign bus.m_arid    = (grant_q == GNT_D) ? ID_D : ID_I;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arlen   = arlen_q;
  assign bus.m_arsize  = 3'b010;
  assign bus.m_arburst = 2'b01;
  assign bus.m_arvalid = (rstate_q == R_ADDR);
  assign bus.m_rready  = 1'b1;

  assign bus.d_awready = (wstate_q == W_IDLE) && bus.d_awvalid;
  assign bus.m_awid    = ID_D;
  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_awlen   = awlen_q;
  assign bus.m_awvalid = (wstate_q == W_ADDR);
  assign bus.m_wdata   = bus.d_wdata;
  assign bus.m_wstrb   = bus.d_wstrb;
  assign bus.m_wlast   = bus.d_wlast;
  assign bus.m_wvalid  = w_pass && bus.d_wvalid;
  assign bus.d_wready  = w_pass && bus.m_wready;
  assign bus.d_bvalid  = (wstate_q == W_RESP) && bus.m_bvalid;
  assign bus.m_bready  = 1'b1;

  assign bus.dcache_active = ((grant_q == GNT_D) && (rstate_q != R_IDLE)) ||
                             bus.d_arvalid || w_busy;

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Bench for axi_bus_arbiter: vector table of read requests plus directed
// write/RAW, dropped-beat and mid-burst reset sequences, with AR/R scoreboards.
module tb_axi_bus_arbiter;
  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
  } ar_exp_t;

  typedef struct {
    logic        to_d;
    logic [31:0] data;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [3:0]  len;
    int          delay;
    logic [3:0]  exp_id;
    logic        exp_active;
  } vec_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic r_busy = 1'b0;
  int   tests = 0;
  int   fails = 0;
  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  ar_exp_t ae;
  r_exp_t  re;
  vec_t    vecs[5];

  axi_bus_arbiter_if bif();

  axi_bus_arbiter #(.LINE_BITS(5), .ID_I(ID_I), .ID_D(ID_D)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bif)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard side: AR handshakes and forwarded R beats.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (bif.m_arvalid && bif.m_arready) begin
        if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          ae = ar_q.pop_front();
          check("araddr", bif.m_araddr, ae.addr);
          check("arlen", {28'd0, bif.m_arlen}, {28'd0, ae.len});
          check("arid", {28'd0, bif.m_arid}, {28'd0, ae.id});
        end
      end
      if (bif.i_rvalid || bif.d_rvalid) begin
        if (r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          re = r_q.pop_front();
          check("r_both", {31'd0, bif.i_rvalid && bif.d_rvalid}, 0);
          check("r_target", {31'd0, bif.d_rvalid}, {31'd0, re.to_d});
          check("rdata", re.to_d ? bif.d_rdata : bif.i_rdata, re.data);
          check("rlast", {31'd0, re.to_d ? bif.d_rlast : bif.i_rlast}, {31'd0, re.last});
        end
      end
      if (r_busy) check("ar_overlap", {31'd0, bif.m_arvalid}, 0);
    end
  end

  task automatic req(input logic is_d, input logic [31:0] addr, input logic [3:0] len,
                     input int budget);
    logic got;
    got = 1'b0;
    if (is_d) begin bif.d_arvalid = 1'b1; bif.d_araddr = addr; bif.d_arlen = len; end
    else      begin bif.i_arvalid = 1'b1; bif.i_araddr = addr; bif.i_arlen = len; end
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge aclk);
      if (is_d ? bif.d_arready : bif.i_arready) begin
        got = 1'b1;
        ar_q.push_back('{addr, len, is_d ? ID_D : ID_I});
      end
      tick();
    end
    if (is_d) bif.d_arvalid = 1'b0;
    else      bif.i_arvalid = 1'b0;
    if (!got) check("arready_timeout", 0, 1);
  endtask

  // Bus slave: accepts one AR after `delay` wait cycles, returns arlen+1 beats.
  task automatic bus_read(input logic to_d, input logic [3:0] id, input int delay,
                          input logic exp_active, input logic inject, input int abort_at);
    logic [3:0]  len;
    logic [31:0] data;
    for (int n = 0; n < 40 && !bif.m_arvalid; n++) tick();
    if (!bif.m_arvalid) begin
      check("ar_timeout", 0, 1);
      return;
    end
    len = bif.m_arlen;
    for (int k = 0; k < delay; k++) begin
      @(negedge aclk);
      check("ar_hold", {31'd0, bif.m_arvalid}, 1);
      tick();
    end
    bif.m_arready = 1'b1;
    @(negedge aclk);
    check("dcache_active", {31'd0, bif.dcache_active}, {31'd0, exp_active});
    tick();
    bif.m_arready = 1'b0;
    r_busy = 1'b1;
    if (inject) begin
      bif.m_rvalid = 1'b1; bif.m_rid = id ^ 4'h1; bif.m_rdata = 32'hDEAD_BEEF; bif.m_rlast = 1'b0;
      @(negedge aclk);
      check("drop_i_rvalid", {31'd0, bif.i_rvalid}, 0);
      check("drop_d_rvalid", {31'd0, bif.d_rvalid}, 0);
      tick();
    end
    for (int b = 0; b <= int'(len); b++) begin
      data = $urandom;
      bif.m_rvalid = 1'b1; bif.m_rid = id; bif.m_rdata = data; bif.m_rlast = (b == int'(len));
      if (b == abort_at) begin
        #1 aresetn = 1'b0;
        @(negedge aclk);
        check("rst_d_rvalid", {31'd0, bif.d_rvalid}, 0);
        check("rst_i_rvalid", {31'd0, bif.i_rvalid}, 0);
        check("rst_m_arvalid", {31'd0, bif.m_arvalid}, 0);
        check("rst_m_awvalid", {31'd0, bif.m_awvalid}, 0);
        check("rst_active", {31'd0, bif.dcache_active}, 0);
        tick();
        bif.m_rvalid = 1'b0; bif.m_rlast = 1'b0;
        r_busy = 1'b0;
        aresetn = 1'b1;
        return;
      end
      r_q.push_back('{to_d, data, b == int'(len)});
      tick();
    end
    bif.m_rvalid = 1'b0; bif.m_rlast = 1'b0;
    r_busy = 1'b0;
  endtask

  initial begin
    logic [31:0] wd;
    vecs[0] = '{1'b0, 32'hBFC0_0000, 4'd7, 3, ID_I, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_1000, 4'd7, 0, ID_D, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0000, 4'd0, 1, ID_I, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFE0, 4'd15, 2, ID_D, 1'b1};
    vecs[4] = '{1'b0, 32'h1234_5670, 4'd3, 0, ID_I, 1'b0};

    bif.i_araddr = '0; bif.i_arlen = '0; bif.i_arvalid = 1'b0;
    bif.d_araddr = '0; bif.d_arlen = '0; bif.d_arvalid = 1'b0;
    bif.d_awaddr = '0; bif.d_awlen = '0; bif.d_awvalid = 1'b0;
    bif.d_wdata = '0; bif.d_wstrb = '0; bif.d_wlast = 1'b0; bif.d_wvalid = 1'b0;
    bif.m_arready = 1'b0; bif.m_rid = '0; bif.m_rdata = '0; bif.m_rlast = 1'b0;
    bif.m_rvalid = 1'b0; bif.m_awready = 1'b0; bif.m_wready = 1'b0; bif.m_bvalid = 1'b0;

    @(negedge aclk);
    check("rst_arvalid", {31'd0, bif.m_arvalid}, 0);
    check("rst_awvalid", {31'd0, bif.m_awvalid}, 0);
    check("rst_wvalid", {31'd0, bif.m_wvalid}, 0);
    check("rst_bvalid", {31'd0, bif.d_bvalid}, 0);
    check("rst_rready", {31'd0, bif.m_rready}, 1);
    check("rst_bready", {31'd0, bif.m_bready}, 1);
    check("rst_dactive", {31'd0, bif.dcache_active}, 0);
    check("arsize", {29'd0, bif.m_arsize}, 32'd2);
    check("arburst", {30'd0, bif.m_arburst}, 32'd1);
    tick();
    aresetn = 1'b1;
    tick();

    foreach (vecs[v]) begin
      fork
        req(vecs[v].is_d, vecs[v].addr, vecs[v].len, 40);
        bus_read(vecs[v].is_d, vecs[v].exp_id, vecs[v].delay, vecs[v].exp_active, 1'b0, -1);
      join
    end

    // Both masters request together: dcache first, icache after its burst.
    bif.d_arvalid = 1'b1; bif.d_araddr = 32'h1000; bif.d_arlen = 4'd7;
    bif.i_arvalid = 1'b1; bif.i_araddr = 32'h8000; bif.i_arlen = 4'd3;
    @(negedge aclk);
    check("prio_d_arready", {31'd0, bif.d_arready}, 1);
    check("prio_i_arready", {31'd0, bif.i_arready}, 0);
    check("no_comb_arvalid", {31'd0, bif.m_arvalid}, 0);
    ar_q.push_back('{32'h1000, 4'd7, ID_D});
    tick();
    bif.d_arvalid = 1'b0;
    @(negedge aclk);
    check("cyc1_arvalid", {31'd0, bif.m_arvalid}, 1);
    check("cyc1_araddr", bif.m_araddr, 32'h1000);
    check("cyc1_arid", {28'd0, bif.m_arid}, {28'd0, ID_D});
    tick();
    fork
      req(1'b0, 32'h8000, 4'd3, 60);
      begin
        bus_read(1'b1, ID_D, 0, 1'b1, 1'b0, -1);
        bus_read(1'b0, ID_I, 0, 1'b0, 1'b0, -1);
      end
    join

    // Write with late AW and W beats first, plus read-after-write blocking.
    bif.d_awvalid = 1'b1; bif.d_awaddr = 32'h2000; bif.d_awlen = 4'd7;
    @(negedge aclk);
    check("d_awready", {31'd0, bif.d_awready}, 1);
    tick();
    bif.d_awvalid = 1'b0;
    @(negedge aclk);
    check("awvalid", {31'd0, bif.m_awvalid}, 1);
    tick();
    bif.m_wready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      wd = $urandom;
      bif.d_wvalid = 1'b1; bif.d_wdata = wd; bif.d_wstrb = 4'(b); bif.d_wlast = (b == 7);
      @(negedge aclk);
      check("m_wvalid", {31'd0, bif.m_wvalid}, 1);
      check("m_wdata", bif.m_wdata, wd);
      check("m_wstrb", {28'd0, bif.m_wstrb}, 32'(b));
      check("m_wlast", {31'd0, bif.m_wlast}, {31'd0, b == 7});
      check("d_wready", {31'd0, bif.d_wready}, 1);
      tick();
    end
    bif.d_wvalid = 1'b0; bif.d_wlast = 1'b0;
    @(negedge aclk);
    check("aw_wait", {31'd0, bif.m_awvalid}, 1);
    tick();
    bif.i_arvalid = 1'b1; bif.i_araddr = 32'h2010; bif.i_arlen = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("raw_block_arready", {31'd0, bif.i_arready}, 0);
      check("raw_block_arvalid", {31'd0, bif.m_arvalid}, 0);
      tick();
    end
    bif.m_awready = 1'b1;
    @(negedge aclk);
    check("awaddr", bif.m_awaddr, 32'h2000);
    check("awlen", {28'd0, bif.m_awlen}, 32'd7);
    check("awid", {28'd0, bif.m_awid}, {28'd0, ID_D});
    tick();
    bif.m_awready = 1'b0;
    @(negedge aclk);
    check("resp_awvalid", {31'd0, bif.m_awvalid}, 0);
    check("resp_bvalid_early", {31'd0, bif.d_bvalid}, 0);
    check("raw_block_resp", {31'd0, bif.i_arready}, 0);
    tick();
    bif.i_araddr = 32'h3000; bif.i_arlen = 4'd1;
    @(negedge aclk);
    check("raw_other_line", {31'd0, bif.i_arready}, 1);
    ar_q.push_back('{32'h3000, 4'd1, ID_I});
    tick();
    bif.i_arvalid = 1'b0;
    bus_read(1'b0, ID_I, 1, 1'b1, 1'b0, -1);
    bif.i_arvalid = 1'b1; bif.i_araddr = 32'h2010; bif.i_arlen = 4'd3;
    @(negedge aclk);
    check("raw_block_again", {31'd0, bif.i_arready}, 0);
    tick();
    bif.m_bvalid = 1'b1;
    @(negedge aclk);
    check("d_bvalid", {31'd0, bif.d_bvalid}, 1);
    check("raw_block_bvalid", {31'd0, bif.i_arready}, 0);
    tick();
    bif.m_bvalid = 1'b0;
    @(negedge aclk);
    check("d_bvalid_pulse", {31'd0, bif.d_bvalid}, 0);
    check("w_idle_active", {31'd0, bif.dcache_active}, 0);
    check("raw_release", {31'd0, bif.i_arready}, 1);
    ar_q.push_back('{32'h2010, 4'd3, ID_I});
    tick();
    bif.i_arvalid = 1'b0;
    bus_read(1'b0, ID_I, 0, 1'b0, 1'b0, -1);

    // Foreign-id beat during an icache burst is dropped.
    fork
      req(1'b0, 32'h4000, 4'd1, 40);
      bus_read(1'b0, ID_I, 0, 1'b0, 1'b1, -1);
    join

    // Reset during the 4th beat, then a fresh burst.
    fork
      req(1'b1, 32'h5000, 4'd7, 40);
      bus_read(1'b1, ID_D, 0, 1'b1, 1'b0, 3);
    join
    tick();
    fork
      req(1'b1, 32'h6000, 4'd3, 40);
      bus_read(1'b1, ID_D, 0, 1'b1, 1'b0, -1);
    join

    repeat (3) tick();
    check("ar_q_empty", ar_q.size(), 0);
    check("r_q_empty", r_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_bus_arbiter.md
Name: axi_bus_arbiter

Overview:
- Shares the core's single AXI3 master port between the icache refill/uncache engine (read only) and the dcache engine (read and write).
- Sequences one outstanding read burst and one outstanding write burst at a time.
- Blocks a read that targets a line whose write is still in flight.
- Drives the dcache_active stall input of the icache engine.

Parameters:
- LINE_BITS, 5, log2 of cache line bytes, used for read-after-write line comparison
- ID_I, 4'd0, arid issued for icache reads
- ID_D, 4'd1, arid and awid issued for dcache transactions

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- i_araddr/i_arlen/i_arvalid  in  32/4/1  icache AR request
- i_arready  out  1  icache AR accepted
- i_rdata/i_rlast/i_rvalid  out  32/1/1  icache R beat
- d_araddr/d_arlen/d_arvalid  in  32/4/1  dcache AR request
- d_arready  out  1  dcache AR accepted
- d_rdata/d_rlast/d_rvalid  out  32/1/1  dcache R beat
- d_awaddr/d_awlen/d_awvalid  in  32/4/1  dcache AW request
- d_awready  out  1  dcache AW accepted
- d_wdata/d_wstrb/d_wlast/d_wvalid  in  32/4/1/1  dcache W beat
- d_wready  out  1  dcache W accepted
- d_bvalid  out  1  dcache write response
- m_arid/m_araddr/m_arlen/m_arvalid  out  4/32/4/1  bus AR; arsize=3'b010 and arburst=2'b01 are tied at top
- m_arready  in  1  bus AR ready
- m_rid/m_rdata/m_rlast/m_rvalid  in  4/32/1/1  bus R
- m_rready  out  1  always 1
- m_awid/m_awaddr/m_awlen/m_awvalid  out  4/32/4/1  bus AW
- m_awready  in  1  bus AW ready
- m_wdata/m_wstrb/m_wlast/m_wvalid  out  32/4/1/1  bus W
- m_wready  in  1  bus W ready
- m_bvalid  in  1  bus B valid
- m_bready  out  1  always 1
- dcache_active  out  1  dcache owns, or is requesting, the read channel or has a write in flight

Behaviour:
- Reset: all valid/ready outputs 0, m_rready=m_bready=1, both FSMs idle, grant register 0, write line register 0, dcache_active 0.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
- R_IDLE:
  - If d_arvalid and no RAW block: grant=D. The dcache always wins when both masters request.
  - Else if i_arvalid and no RAW block: grant=I.
  - A grant latches the request address/len into registers and moves to R_ADDR. No combinational path exists from request to m_arvalid (1-cycle latency).
- R_ADDR:
  - m_arvalid=1 with the latched address/len; arid=ID_I or ID_D per grant.
  - The granted x_arready pulses for exactly one cycle, in the R_IDLE->R_ADDR grant cycle.
  - On m_arready: go to R_DATA.
- R_DATA:
  - Route m_rdata/m_rlast to both masters; x_rvalid is asserted only for the granted master (m_rvalid qualified by grant).
  - On m_rvalid&m_rlast: go to R_IDLE. A new grant may be taken on the following cycle, not the same cycle.
  - R beats whose m_rid differs from the granted id are dropped (never forwarded).
- RAW block: a read is blocked while the write FSM is not idle and read_addr[31:LINE_BITS] equals write_addr[31:LINE_BITS].
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
- W_IDLE: on d_awvalid, pulse d_awready for 1 cycle, latch addr/len, go to W_ADDR.
- W_ADDR:
  - m_awvalid=1; on m_awready go to W_DATA.
  - If m_awready arrives while W beats are already flowing, that is legal: W beats pass through in W_ADDR and W_DATA alike.
- W_DATA: m_wvalid=d_wvalid, d_wready=m_wready, data/strb/last passed through.
- W_RESP:
  - Entered on the last beat handshake (d_wvalid&m_wready&d_wlast) once AW has completed; if AW is not yet accepted, wait for it in W_ADDR.
  - On m_bvalid: d_bvalid=1 for 1 cycle, go to W_IDLE.
- Read and write FSMs run concurrently.
- dcache_active = (grant==D & read FSM not idle) | d_arvalid | write FSM not idle; it is combinational on d_arvalid.
- Async reset mid-burst: both FSMs return to idle immediately and any partial burst is abandoned. Bus-side recovery is the reset domain's responsibility.

Test Plan:
- Simultaneous i_arvalid and d_arvalid in cycle 0, d addr 0x1000 len 7 -> m_arvalid in cycle 1 with araddr 0x1000, arid 1. After 8 beats the icache request is issued with arid 0, no overlap.
- Icache only, addr 0xBFC00000 len 7, m_arready delayed 3 cycles -> m_arvalid held steady 3 cycles. 8 beats appear on i_rvalid, d_rvalid stays 0, dcache_active stays 0.
- Dcache write 0x2000 len 7 with awready late, W beats first -> all 8 beats pass, d_bvalid pulses once after m_bvalid, FSM back to W_IDLE.
- Write in flight to 0x2000, icache read 0x2010 -> read held (no m_arvalid) until d_bvalid. A read to 0x3000 issued during the same write proceeds immediately.
- R beat with rid=1 while grant=I -> not forwarded, i_rvalid stays 0.
- aresetn asserted during the 4th read beat -> all valids 0 the same cycle. After release, a fresh request is issued normally.
